// File: rtl/cordic_cmd_sched_if.sv
// Command-side handshake between the register file (master) and the CORDIC
// command scheduler (slave).
interface cordic_cmd_sched_if #(
   parameter int W = 32
);
   logic           cmd_valid;
   logic           cmd_ready;
   logic [2:0]     cmd_func;
   logic [4*W-1:0] cmd_ops;
   logic [4:0]     cmd_xyfrac;
   logic [4:0]     cmd_phfrac;

   modport master (
      output cmd_valid, cmd_func, cmd_ops, cmd_xyfrac, cmd_phfrac,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_func, cmd_ops, cmd_xyfrac, cmd_phfrac,
      output cmd_ready
   );
endinterface

// File: rtl/cordic_cmd_sched.sv
// Queues CORDIC commands and issues them one at a time to the control engine,
// reloading the constant/arctan tables only when the numeric format changes.
module cordic_cmd_sched #(
   parameter int W       = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int CNTW    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   cordic_cmd_sched_if.slave cmd,
   output logic              eng_start,
   output logic              eng_abort,
   output logic [2:0]        eng_func,
   output logic [4*W-1:0]    eng_ops,
   output logic [4:0]        eng_xyfrac,
   output logic [4:0]        eng_phfrac,
   output logic              tbl_update,
   input  logic              eng_done,
   output logic              res_valid,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overflow,
   input  logic              err_clr,
   output logic [CNTW-1:0]   done_cnt
);
   // state | meaning
   // IDLE  | wait for a queued command; pop it and decide whether tables reload
   // LOAD  | tbl_update pulse, new format presented on eng_xyfrac/eng_phfrac
   // START | eng_start pulse, timeout counter cleared
   // BUSY  | wait for eng_done or timeout
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_BUSY} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3 + 4*W + 10;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   state_t         state;
   logic [EW-1:0]  mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [TW-1:0]  tmo_cnt;
   logic           fmt_valid;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           fmt_change;
   logic [EW-1:0]  head;
   logic [2:0]     head_func;
   logic [4*W-1:0] head_ops;
   logic [4:0]     head_xy;
   logic [4:0]     head_ph;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd.cmd_ready = !full;
   assign push  = cmd.cmd_valid && !full;
   assign pop   = (state == ST_IDLE) && !empty;
   assign busy  = (state != ST_IDLE) || !empty;

   assign head = mem[rd_ptr[AW-1:0]];
   assign {head_func, head_ops, head_xy, head_ph} = head;
   assign fmt_change = !fmt_valid || (head_xy != eng_xyfrac) || (head_ph != eng_phfrac);

   // Storage is not reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd.cmd_func, cmd.cmd_ops, cmd.cmd_xyfrac, cmd.cmd_phfrac};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         eng_start    <= 1'b0;
         eng_abort    <= 1'b0;
         eng_func     <= '0;
         eng_ops      <= '0;
         eng_xyfrac   <= '0;
         eng_phfrac   <= '0;
         tbl_update   <= 1'b0;
         res_valid    <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
         done_cnt     <= '0;
         tmo_cnt      <= '0;
         fmt_valid    <= 1'b0;
      end else begin
         eng_start  <= 1'b0;
         eng_abort  <= 1'b0;
         tbl_update <= 1'b0;
         res_valid  <= 1'b0;

         // Clear first so a same-cycle set condition below takes priority.
         if (err_clr) begin
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
         end
         if (cmd.cmd_valid && full) err_overflow <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (pop) begin
                  eng_func <= head_func;
                  eng_ops  <= head_ops;
                  if (fmt_change) begin
                     eng_xyfrac <= head_xy;
                     eng_phfrac <= head_ph;
                     fmt_valid  <= 1'b1;
                     tbl_update <= 1'b1;
                     state      <= ST_LOAD;
                  end else begin
                     eng_start <= 1'b1;
                     state     <= ST_START;
                  end
               end
            end
            ST_LOAD: begin
               eng_start <= 1'b1;
               state     <= ST_START;
            end
            ST_START: begin
               tmo_cnt <= '0;
               state   <= ST_BUSY;
            end
            ST_BUSY: begin
               tmo_cnt <= tmo_cnt + TMO_ONE;
               if (eng_done) begin
                  res_valid <= 1'b1;
                  done_cnt  <= done_cnt + CNT_ONE;
                  state     <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  eng_abort   <= 1'b1;
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
